ecc_ahb_slv_sif: RTL and testbench
==================================

// Module: ecc_ahb_slv_sif
// PURPOSE
// - AHB-lite slave front-end sitting directly upstream of the ECC register block inside ecc_top.
// - Converts pipelined AHB-lite address/data phases into a single-cycle register request (dv/write/addr/wdata).
// - Returns read data and wait/error responses to the fabric.
// - Checks transfer legality (size, alignment) and produces the AHB two-cycle ERROR response.
// PARAMETERS
// - AHB_ADDR_WIDTH     32  width of haddr_i
// - AHB_DATA_WIDTH     32  width of hwdata_i/hrdata_o; only 32 is supported
// - CLIENT_ADDR_WIDTH  12  width of addr_o; haddr_i[CLIENT_ADDR_WIDTH-1:0] is forwarded
// PORTS
// - clk          in   1    clock
// - reset        in   1    asynchronous, active-high reset
// - haddr_i      in   AHB_ADDR_WIDTH  AHB address
// - hwdata_i     in   AHB_DATA_WIDTH  AHB write data (valid in data phase)
// - hsel_i       in   1    slave select
// - hwrite_i     in   1    1=write
// - hready_i     in   1    bus ready (previous transfer done)
// - htrans_i     in   2    IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
// - hsize_i      in   3    transfer size; only 3'b010 is legal
// - hresp_o      out  1    1=ERROR
// - hreadyout_o  out  1    0=wait state
// - hrdata_o     out  AHB_DATA_WIDTH  read data
// - dv_o         out  1    register request valid (data phase)
// - write_o      out  1    request is a write
// - addr_o       out  CLIENT_ADDR_WIDTH  request address
// - wdata_o      out  AHB_DATA_WIDTH  request write data (= hwdata_i)
// - hold_i       in   1    register block stalls the current request
// - rdata_i      in   AHB_DATA_WIDTH  register read data, valid when dv_o & !write_o & !hold_i
// - err_i        in   1    register block rejects the request (sampled with dv_o & !hold_i)
// BEHAVIOUR
// - Reset values: hresp_o=0, hreadyout_o=1, hrdata_o=0, dv_o=0, write_o=0, addr_o=0; state=IDLE.
// - Address-phase accept: hsel_i & hready_i & htrans_i[1].
//   - On accept, register write and addr[CLIENT_ADDR_WIDTH-1:0].
//   - Legal = hsize_i==3'b010 and haddr_i[1:0]==0.
// - FSM (states IDLE, DATA, ERR1, ERR2):
//   - IDLE: legal accept -> DATA; illegal accept -> ERR1; else stay.
//   - DATA: dv_o=1; hreadyout_o=!hold_i.
//     - hold_i=1: stay; registered addr/write stay frozen.
//     - hold_i=0 & err_i=1: -> ERR1.
//     - hold_i=0 & err_i=0: transfer completes; a simultaneous new accept -> DATA/ERR1 per legality (back-to-back, no bubble); else -> IDLE.
//   - ERR1: hresp_o=1, hreadyout_o=0, dv_o=0 -> ERR2.
//   - ERR2: hresp_o=1, hreadyout_o=1.
//     - An accept in this cycle is honoured exactly as in IDLE.
//     - Otherwise -> IDLE.
// - BUSY/IDLE htrans with hsel_i: zero-wait OKAY; no request issued.
// - Read data:
//   - hrdata_o = rdata_i (combinational) when DATA & !write & !hold_i; else 0.
//   - No extra latency: a 0-wait read completes in its data-phase cycle.
// - Writes: wdata_o = hwdata_i, combinational, during the data phase.
// - dv_o is never asserted in ERR1/ERR2 or for illegal transfers; an illegal write must not reach the register block.
// - Reset asserted mid-transfer: all outputs return to reset values asynchronously; the in-flight request is dropped.
// - hsel_i deasserting during a held DATA phase has no effect; the data phase runs to completion.
// STRUCTURE
// - Shared package ahb_sif_pkg:
//   - htrans encodings (AHB_IDLE/BUSY/NONSEQ/SEQ);
//   - AHB_SIZE_WORD=3'b010;
//   - enum ahb_sif_state_e {IDLE,DATA,ERR1,ERR2}.
// - Single flat module: one FSM, address/write capture registers, combinational response decode.
// - No sub-module.
// TESTING
// - Reset: assert reset mid-DATA with hold_i=1 -> hreadyout_o=1, hresp_o=0, dv_o=0 immediately.
// - Write: NONSEQ write, haddr=0x10, hwdata=0xA5A5_0001, hold_i=0.
//   - Next cycle: dv_o=1, write_o=1, addr_o=0x010, wdata_o=0xA5A5_0001, hreadyout_o=1.
// - Read with wait: NONSEQ read addr 0x24, hold_i=1 for 2 cycles, rdata_i=0x1234_5678.
//   - hreadyout_o=0,0,1; hrdata_o=0x1234_5678 on the third cycle.
// - Back-to-back: write 0x00 then read 0x04 on consecutive address phases.
//   - dv_o high 2 consecutive cycles with addr_o 0x000 then 0x004; no idle cycle between.
// - Illegal size: hsize_i=3'b001 write at 0x08.
//   - dv_o never set; hresp_o=1/hreadyout_o=0, then hresp_o=1/hreadyout_o=1, then OKAY.
// - Slave error: err_i=1 with read at 0x30.
//   - Two-cycle ERROR response; a NONSEQ issued in ERR2 is served normally next cycle.

Source files
------------

// File: rtl/ahb_sif_pkg.sv
// Shared AHB-lite encodings and the slave front-end state type.
package ahb_sif_pkg;

   localparam logic [1:0] AHB_IDLE      = 2'b00;
   localparam logic [1:0] AHB_BUSY      = 2'b01;
   localparam logic [1:0] AHB_NONSEQ    = 2'b10;
   localparam logic [1:0] AHB_SEQ       = 2'b11;
   localparam logic [2:0] AHB_SIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } ahb_sif_state_e;

endpackage

// File: rtl/ecc_ahb_slv_sif.sv
// AHB-lite slave front-end: turns AHB address/data phases into a one-cycle
// register request and builds the OKAY / wait / two-cycle ERROR responses.
module ecc_ahb_slv_sif
   import ahb_sif_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH    = 32,
   parameter int AHB_DATA_WIDTH    = 32,
   parameter int CLIENT_ADDR_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
   input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
   input  logic                         hsel_i,
   input  logic                         hwrite_i,
   input  logic                         hready_i,
   input  logic [1:0]                   htrans_i,
   input  logic [2:0]                   hsize_i,
   output logic                         hresp_o,
   output logic                         hreadyout_o,
   output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
   output logic                         dv_o,
   output logic                         write_o,
   output logic [CLIENT_ADDR_WIDTH-1:0] addr_o,
   output logic [AHB_DATA_WIDTH-1:0]    wdata_o,
   input  logic                         hold_i,
   input  logic [AHB_DATA_WIDTH-1:0]    rdata_i,
   input  logic                         err_i,
   output ahb_sif_state_e               dbg_state
);

   ahb_sif_state_e               state;
   logic                         write_q;
   logic [CLIENT_ADDR_WIDTH-1:0] addr_q;

   logic accept;
   logic legal;
   logic complete;
   logic take;
   logic unused_haddr_hi;

   assign accept = hsel_i & hready_i & htrans_i[1];
   assign legal  = (hsize_i == AHB_SIZE_WORD) && (haddr_i[1:0] == 2'b00);

   // A new address phase is only taken when no data phase is still pending;
   // an errored completion drops any overlapping address phase.
   assign complete = (state == DATA) && !hold_i && !err_i;
   assign take     = accept && ((state == IDLE) || (state == ERR2) || complete);

   assign unused_haddr_hi = ^haddr_i[AHB_ADDR_WIDTH-1:CLIENT_ADDR_WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         if (take) begin
            write_q <= hwrite_i;
            addr_q  <= haddr_i[CLIENT_ADDR_WIDTH-1:0];
         end
         unique case (state)
            IDLE, ERR2: begin
               if (take) state <= legal ? DATA : ERR1;
               else      state <= IDLE;
            end
            DATA: begin
               if (!hold_i) begin
                  if (err_i)     state <= ERR1;
                  else if (take) state <= legal ? DATA : ERR1;
                  else           state <= IDLE;
               end
            end
            ERR1:    state <= ERR2;
            default: state <= IDLE;
         endcase
      end
   end

   assign dv_o        = (state == DATA);
   assign write_o     = write_q;
   assign addr_o      = addr_q;
   assign wdata_o     = hwdata_i;
   assign hresp_o     = (state == ERR1) || (state == ERR2);
   assign hreadyout_o = (state == DATA) ? !hold_i : (state != ERR1);
   assign hrdata_o    = ((state == DATA) && !write_q && !hold_i) ? rdata_i : '0;
   assign dbg_state   = state;

endmodule

// File: tb/tb_ecc_ahb_slv_sif.sv
// Bench for ecc_ahb_slv_sif: directed protocol scenarios followed by a
// randomized AHB master scored against a transaction-level model.
module tb_ecc_ahb_slv_sif;
   import ahb_sif_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hsel;
   logic        hwrite;
   logic        hready;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hresp;
   logic        hreadyout;
   logic [31:0] hrdata;
   logic        dv;
   logic        write;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic        hold;
   logic [31:0] rdata;
   logic        err;
   ahb_sif_state_e dbg_state;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q[$];
   int          exp_err = 0;
   int          obs_err = 0;

   // Single slave on the bus: its own ready is the fabric ready.
   assign hready = hreadyout;

   ecc_ahb_slv_sif #(
      .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .CLIENT_ADDR_WIDTH(12)
   ) dut (
      .clk(clk), .reset(reset), .haddr_i(haddr), .hwdata_i(hwdata),
      .hsel_i(hsel), .hwrite_i(hwrite), .hready_i(hready), .htrans_i(htrans),
      .hsize_i(hsize), .hresp_o(hresp), .hreadyout_o(hreadyout),
      .hrdata_o(hrdata), .dv_o(dv), .write_o(write), .addr_o(addr),
      .wdata_o(wdata), .hold_i(hold), .rdata_i(rdata), .err_i(err),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      hsel   = 1'b0;
      htrans = AHB_IDLE;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
      hsel   = 1'b1;
      htrans = AHB_NONSEQ;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
   endtask

   initial begin
      logic [12:0] e;
      logic        pend;
      logic        lgl;

      reset = 1'b1; haddr = '0; hwdata = '0; hsel = 1'b0; hwrite = 1'b0;
      htrans = AHB_IDLE; hsize = AHB_SIZE_WORD; hold = 1'b0; rdata = '0; err = 1'b0;
      @(negedge clk);
      check("rst_hresp", hresp, 0);
      check("rst_hready", hreadyout, 1);
      check("rst_dv", dv, 0);
      check("rst_addr", addr, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      cyc();
      reset = 1'b0;

      // Zero-wait write
      addr_phase(32'h10, 1'b1, AHB_SIZE_WORD);
      @(negedge clk);
      check("wr_aphase_dv", dv, 0);
      cyc();
      idle_bus(); hwdata = 32'hA5A5_0001; hold = 1'b0;
      @(negedge clk);
      check("wr_dv", dv, 1);
      check("wr_write", write, 1);
      check("wr_addr", addr, 12'h010);
      check("wr_wdata", wdata, 32'hA5A5_0001);
      check("wr_hready", hreadyout, 1);
      cyc();
      @(negedge clk);
      check("wr_after_dv", dv, 0);

      // Read with two wait states
      cyc();
      addr_phase(32'h24, 1'b0, AHB_SIZE_WORD);
      cyc();
      idle_bus(); hold = 1'b1; rdata = 32'h1234_5678;
      @(negedge clk);
      check("rdw_hready0", hreadyout, 0);
      check("rdw_hrdata0", hrdata, 0);
      cyc();
      @(negedge clk);
      check("rdw_hready1", hreadyout, 0);
      check("rdw_addr1", addr, 12'h024);
      cyc();
      hold = 1'b0;
      @(negedge clk);
      check("rdw_hready2", hreadyout, 1);
      check("rdw_hrdata2", hrdata, 32'h1234_5678);
      cyc();
      @(negedge clk);
      check("rdw_after_dv", dv, 0);

      // Back-to-back write then read
      cyc();
      addr_phase(32'h00, 1'b1, AHB_SIZE_WORD);
      cyc();
      addr_phase(32'h04, 1'b0, AHB_SIZE_WORD); hwdata = 32'hCAFE_0000;
      @(negedge clk);
      check("b2b_dv0", dv, 1);
      check("b2b_addr0", addr, 12'h000);
      check("b2b_write0", write, 1);
      cyc();
      idle_bus(); rdata = 32'h0BAD_F00D;
      @(negedge clk);
      check("b2b_dv1", dv, 1);
      check("b2b_addr1", addr, 12'h004);
      check("b2b_write1", write, 0);
      check("b2b_hrdata1", hrdata, 32'h0BAD_F00D);
      cyc();
      @(negedge clk);
      check("b2b_after_dv", dv, 0);

      // Illegal halfword write
      cyc();
      addr_phase(32'h08, 1'b1, 3'b001);
      cyc();
      idle_bus(); hwdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("ill_e1_dv", dv, 0);
      check("ill_e1_hresp", hresp, 1);
      check("ill_e1_hready", hreadyout, 0);
      cyc();
      @(negedge clk);
      check("ill_e2_dv", dv, 0);
      check("ill_e2_hresp", hresp, 1);
      check("ill_e2_hready", hreadyout, 1);
      cyc();
      @(negedge clk);
      check("ill_ok_hresp", hresp, 0);
      check("ill_ok_hready", hreadyout, 1);
      check("ill_ok_dv", dv, 0);

      // Slave error on a read, then a transfer issued during ERR2
      hsize = AHB_SIZE_WORD;
      cyc();
      addr_phase(32'h30, 1'b0, AHB_SIZE_WORD);
      cyc();
      idle_bus(); err = 1'b1;
      @(negedge clk);
      check("serr_dv", dv, 1);
      cyc();
      err = 1'b0;
      @(negedge clk);
      check("serr_e1_hresp", hresp, 1);
      check("serr_e1_hready", hreadyout, 0);
      check("serr_e1_dv", dv, 0);
      cyc();
      addr_phase(32'h40, 1'b0, AHB_SIZE_WORD);
      @(negedge clk);
      check("serr_e2_hresp", hresp, 1);
      check("serr_e2_hready", hreadyout, 1);
      cyc();
      idle_bus(); rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("serr_next_dv", dv, 1);
      check("serr_next_addr", addr, 12'h040);
      check("serr_next_hresp", hresp, 0);
      check("serr_next_hrdata", hrdata, 32'h5555_AAAA);

      // BUSY with select: zero-wait OKAY, no request
      cyc();
      hsel = 1'b1; htrans = AHB_BUSY;
      cyc();
      idle_bus();
      @(negedge clk);
      check("busy_dv", dv, 0);
      check("busy_hready", hreadyout, 1);
      check("busy_hresp", hresp, 0);

      // Reset during a held data phase
      cyc();
      addr_phase(32'h50, 1'b0, AHB_SIZE_WORD);
      cyc();
      hsel = 1'b0; htrans = AHB_IDLE; hold = 1'b1;
      @(negedge clk);
      check("mrst_pre_hready", hreadyout, 0);
      #1 reset = 1'b1;
      #1;
      check("mrst_hready", hreadyout, 1);
      check("mrst_hresp", hresp, 0);
      check("mrst_dv", dv, 0);
      check("mrst_addr", addr, 0);
      cyc();
      reset = 1'b0; hold = 1'b0;

      // Randomized master against the transaction-level model
      pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         if (!pend) begin
            if (c >= 2800 || $urandom_range(0, 9) < 4) begin
               hsel   = 1'($urandom_range(0, 1));
               htrans = $urandom_range(0, 1) ? AHB_BUSY : AHB_IDLE;
            end else begin
               pend   = 1'b1;
               hsel   = 1'b1;
               htrans = $urandom_range(0, 1) ? AHB_NONSEQ : AHB_SEQ;
               hwrite = 1'($urandom_range(0, 1));
               haddr  = $urandom;
               if ($urandom_range(0, 4) != 0) haddr[1:0] = 2'b00;
               hsize  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : AHB_SIZE_WORD;
            end
         end
         hold   = ($urandom_range(0, 3) == 0);
         err    = pend ? 1'b0 : ($urandom_range(0, 4) == 0);
         hwdata = $urandom;
         rdata  = $urandom;
         @(negedge clk);
         if (dv && !hold) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL spurious_dv observed=request addr=%h expected=no request", addr);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rnd_addr", addr, e[11:0]);
               check("rnd_write", write, e[12]);
               if (e[12]) check("rnd_wdata", wdata, hwdata);
               else       check("rnd_rdata", hrdata, rdata);
               if (err) exp_err++;
            end
         end else begin
            check("rnd_hrdata_zero", hrdata, 0);
         end
         if (hresp) check("rnd_dv_in_err", dv, 0);
         if (hresp && !hreadyout) obs_err++;
         if (pend && hreadyout) begin
            pend = 1'b0;
            lgl  = (hsize == AHB_SIZE_WORD) && (haddr[1:0] == 2'b00);
            if (lgl) exp_q.push_back({hwrite, haddr[11:0]});
            else     exp_err++;
         end
      end
      idle_bus(); hold = 1'b0; err = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         @(negedge clk);
         if (hresp && !hreadyout) obs_err++;
      end
      check("rnd_err_count", obs_err, exp_err);
      check("rnd_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
